// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared definitions for the bit-serial magnitude comparator.
//   state_e     : FSM state encodings (IDLE/SHIFT/DONE)
//   clog2_min1  : constant function sizing the bit counter (never below 1 bit)
package serial_magnitude_comparator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // ceil(log2(v)) with a floor of 1 so a WIDTH=1 counter still has a bit.
    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/serial_magnitude_comparator_one_bit_inequality.sv
// 1-bit inequality cell: gt_o is high when a_i > b_i for single bits.
//   a_i  : left-hand bit
//   b_i  : right-hand bit
//   gt_o : a_i & ~b_i
module one_bit_inequality (
    input  logic a_i,
    input  logic b_i,
    output logic gt_o
);

    assign gt_o = a_i & ~b_i;

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator. Latches A/B on start, walks the
// bits MSB-first through two 1-bit inequality cells (one with inputs
// swapped), stops on the first differing bit and reports one-hot gt/eq/lt
// with a single-cycle done pulse.
//   clk, rst_n : clock, async active-low reset
//   start      : request; only honoured in IDLE
//   a, b       : WIDTH-bit unsigned operands, sampled on the accepting edge
//   busy       : high in SHIFT and DONE
//   done       : one-cycle result-valid pulse
//   gt, eq, lt : registered one-hot result, held until the next accept
module serial_magnitude_comparator
    import serial_magnitude_comparator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int CW = clog2_min1(WIDTH);

    state_e           state_q;
    logic [WIDTH-1:0] sra_q;
    logic [WIDTH-1:0] srb_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             gt_q;
    logic             eq_q;
    logic             lt_q;

    logic g_bit;
    logic l_bit;

    // Same cell twice: swapping the inputs turns "a > b" into "a < b".
    one_bit_inequality u_gt (
        .a_i  (sra_q[WIDTH-1]),
        .b_i  (srb_q[WIDTH-1]),
        .gt_o (g_bit)
    );

    one_bit_inequality u_lt (
        .a_i  (srb_q[WIDTH-1]),
        .b_i  (sra_q[WIDTH-1]),
        .gt_o (l_bit)
    );

    // busy/done are registered alongside the state so they track it exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sra_q   <= '0;
            srb_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sra_q   <= a;
                        srb_q   <= b;
                        cnt_q   <= CW'(WIDTH - 1);
                        gt_q    <= 1'b0;
                        eq_q    <= 1'b0;
                        lt_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (g_bit) begin
                        gt_q    <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (l_bit) begin
                        lt_q    <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (cnt_q == '0) begin
                        // Every bit matched down to the LSB.
                        eq_q    <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        sra_q <= sra_q << 1;
                        srb_q <= srb_q << 1;
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign gt   = gt_q;
    assign eq   = eq_q;
    assign lt   = lt_q;

endmodule
